// File: rtl/complex_alu_pipe.sv
// Three-stage pipelined complex ALU: add, sub, Gauss 3-multiplier mul and conjugate mul,
// with round-half-up scaling and saturation. CALU_OVF_COUNT_EN adds a retired-overflow counter.
module complex_alu_pipe #(
  parameter int DW   = 16,
  parameter int FRAC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    op,
  input  logic [DW-1:0] a_re,
  input  logic [DW-1:0] a_im,
  input  logic [DW-1:0] b_re,
  input  logic [DW-1:0] b_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y_re,
  output logic [DW-1:0] y_im,
  output logic [1:0]    out_op,
  output logic          ovf
`ifdef CALU_OVF_COUNT_EN
  ,
  input  logic          ovf_clr,
  output logic [15:0]   ovf_count
`endif
);

  localparam int SW = DW + 1;
  localparam int KW = 2 * DW + 2;
  localparam int RW = 2 * DW + 3;
  localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [RW-1:0] RND = (FRAC > 0) ? (RW'(1) << RND_SH) : '0;
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_CMUL = 2'b11
  } op_e;

  // {saturated, clamped value}
  function automatic logic [DW:0] sat(input logic signed [RW-1:0] v);
    if (v > SAT_MAX)      return {1'b1, SAT_MAX[DW-1:0]};
    else if (v < SAT_MIN) return {1'b1, SAT_MIN[DW-1:0]};
    else                  return {1'b0, v[DW-1:0]};
  endfunction

  logic en;

  // S1 state
  logic                 s1_v_q;
  op_e                  s1_op_q;
  logic signed [DW-1:0] s1_are_q, s1_aim_q, s1_bre_q;
  logic signed [SW-1:0] s1_bim_q, s1_p_q, s1_q_q;
  // S2 state
  logic                 s2_v_q;
  op_e                  s2_op_q;
  logic signed [KW-1:0] s2_k1_q, s2_k2_q, s2_k3_q;
  // S3 / output state
  logic                 out_valid_q;
  logic [DW-1:0]        y_re_q, y_im_q;
  logic [1:0]           out_op_q;
  logic                 ovf_q;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign y_re      = y_re_q;
  assign y_im      = y_im_q;
  assign out_op    = out_op_q;
  assign ovf       = ovf_q;

  // ---------------- S1: pre-sums ----------------
  op_e                  op_in;
  logic signed [SW-1:0] are_x, aim_x, bre_x, bim_x, bim_c;
  logic signed [SW-1:0] p_d, q_d;

  always_comb begin
    op_in = op_e'(op);
    are_x = SW'($signed(a_re));
    aim_x = SW'($signed(a_im));
    bre_x = SW'($signed(b_re));
    bim_x = SW'($signed(b_im));
    // Negation at DW+1 bits keeps conj of the most negative b_im exact.
    bim_c = (op_in == OP_CMUL) ? -bim_x : bim_x;
    p_d   = '0;
    q_d   = '0;
    unique case (op_in)
      OP_ADD: begin
        p_d = are_x + bre_x;
        q_d = aim_x + bim_x;
      end
      OP_SUB: begin
        p_d = are_x - bre_x;
        q_d = aim_x - bim_x;
      end
      default: begin
        p_d = are_x + aim_x;
        q_d = bre_x + bim_c;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      s1_op_q  <= OP_ADD;
      s1_are_q <= '0;
      s1_aim_q <= '0;
      s1_bre_q <= '0;
      s1_bim_q <= '0;
      s1_p_q   <= '0;
      s1_q_q   <= '0;
    end else if (en) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_op_q  <= op_in;
        s1_are_q <= $signed(a_re);
        s1_aim_q <= $signed(a_im);
        s1_bre_q <= $signed(b_re);
        s1_bim_q <= bim_c;
        s1_p_q   <= p_d;
        s1_q_q   <= q_d;
      end
    end
  end

  // ---------------- S2: three products ----------------
  logic                 s1_mul;
  logic signed [KW-1:0] k1_d, k2_d, k3_d;

  always_comb begin
    s1_mul = (s1_op_q == OP_MUL) || (s1_op_q == OP_CMUL);
    k1_d   = '0;
    k2_d   = '0;
    k3_d   = '0;
    if (s1_mul) begin
      k1_d = KW'(s1_are_q) * KW'(s1_bre_q);
      k2_d = KW'(s1_aim_q) * KW'(s1_bim_q);
      k3_d = KW'(s1_p_q) * KW'(s1_q_q);
    end else begin
      // Add/sub results ride through in the k1/k2 slots.
      k1_d = KW'(s1_p_q);
      k2_d = KW'(s1_q_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q  <= 1'b0;
      s2_op_q <= OP_ADD;
      s2_k1_q <= '0;
      s2_k2_q <= '0;
      s2_k3_q <= '0;
    end else if (en) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_op_q <= s1_op_q;
        s2_k1_q <= k1_d;
        s2_k2_q <= k2_d;
        s2_k3_q <= k3_d;
      end
    end
  end

  // ---------------- S3: combine, round, saturate ----------------
  logic                 s2_mul;
  logic signed [RW-1:0] re_w, im_w, re_r, im_r;
  logic [DW:0]          re_s, im_s;

  always_comb begin
    s2_mul = (s2_op_q == OP_MUL) || (s2_op_q == OP_CMUL);
    re_w   = RW'(s2_k1_q) - RW'(s2_k2_q);
    im_w   = RW'(s2_k3_q) - RW'(s2_k1_q) - RW'(s2_k2_q);
    if (s2_mul) begin
      re_r = (re_w + RND) >>> FRAC;
      im_r = (im_w + RND) >>> FRAC;
    end else begin
      re_r = RW'(s2_k1_q);
      im_r = RW'(s2_k2_q);
    end
    re_s = sat(re_r);
    im_s = sat(im_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_re_q      <= '0;
      y_im_q      <= '0;
      out_op_q    <= '0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= s2_v_q;
      if (s2_v_q) begin
        y_re_q   <= re_s[DW-1:0];
        y_im_q   <= im_s[DW-1:0];
        out_op_q <= s2_op_q;
        ovf_q    <= re_s[DW] | im_s[DW];
      end
    end
  end

`ifdef CALU_OVF_COUNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr)
      ovf_cnt_d = '0;
    else if (out_valid_q && out_ready && ovf_q && (ovf_cnt_q != '1))
      ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_complex_alu_pipe.sv
// Bench for complex_alu_pipe: FRAC=0 and FRAC=15 instances share stimulus and are
// checked against an integer-arithmetic reference; CALU_OVF_COUNT_EN adds counter tests.
module tb_complex_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready;
  logic [1:0]  op;
  logic [15:0] a_re, a_im, b_re, b_im;
  logic        rdy0, ov0, ovf0, rdy1, ov1, ovf1;
  logic [15:0] yr0, yi0, yr1, yi1;
  logic [1:0]  oop0, oop1;
`ifdef CALU_OVF_COUNT_EN
  logic        ovf_clr;
  logic [15:0] cnt0, cnt1;
`endif

  complex_alu_pipe #(.DW(16), .FRAC(0)) u_f0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .op(op),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(ov0), .out_ready(out_ready), .y_re(yr0), .y_im(yi0),
    .out_op(oop0), .ovf(ovf0)
`ifdef CALU_OVF_COUNT_EN
    , .ovf_clr(ovf_clr), .ovf_count(cnt0)
`endif
  );

  complex_alu_pipe #(.DW(16), .FRAC(15)) u_f15 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .op(op),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(ov1), .out_ready(out_ready), .y_re(yr1), .y_im(yi1),
    .out_op(oop1), .ovf(ovf1)
`ifdef CALU_OVF_COUNT_EN
    , .ovf_clr(ovf_clr), .ovf_count(cnt1)
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] ar, ai, br, bi;
    int          cyc;
  } txn_t;

  typedef struct {
    logic [34:0] r0, r1;
    logic        v1;
    int          cyc;
  } res_t;

  txn_t inq[$];
  res_t outq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_n = 0;
  bit   acc;

  // Reference: exact complex arithmetic, then scale (mul only), then clamp.
  function automatic logic [34:0] model(input txn_t t, input int frac);
    longint ar = longint'($signed(t.ar));
    longint ai = longint'($signed(t.ai));
    longint br = longint'($signed(t.br));
    longint bi = longint'($signed(t.bi));
    longint re, im;
    logic   o = 1'b0;
    case (t.op)
      2'd0:    begin re = ar + br;           im = ai + bi;           end
      2'd1:    begin re = ar - br;           im = ai - bi;           end
      2'd2:    begin re = ar * br - ai * bi; im = ar * bi + ai * br; end
      default: begin re = ar * br + ai * bi; im = ai * br - ar * bi; end
    endcase
    if (t.op[1] && frac > 0) begin
      re = (re + (longint'(1) << (frac - 1))) >>> frac;
      im = (im + (longint'(1) << (frac - 1))) >>> frac;
    end
    if (re > 32767)  begin re = 32767;  o = 1'b1; end
    if (re < -32768) begin re = -32768; o = 1'b1; end
    if (im > 32767)  begin im = 32767;  o = 1'b1; end
    if (im < -32768) begin im = -32768; o = 1'b1; end
    return {16'(re), 16'(im), t.op, o};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom % 5)
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'(($urandom % 9)) - 16'd4;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive(input bit v, input logic [1:0] o,
                       input logic [15:0] ar, input logic [15:0] ai,
                       input logic [15:0] br, input logic [15:0] bi);
    in_valid = v; op = o; a_re = ar; a_im = ai; b_re = br; b_im = bi;
  endtask

  // One clock: sample handshakes mid-low-phase, record transfers, return at next negedge.
  task automatic cyc();
    #1;
    acc = in_valid && rdy0;
    if (acc) inq.push_back('{op, a_re, a_im, b_re, b_im, cyc_n});
    if (ov0 && out_ready)
      outq.push_back('{{yr0, yi0, oop0, ovf0}, {yr1, yi1, oop1, ovf1}, ov1, cyc_n});
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'd0, '0, '0, '0, '0);
`ifdef CALU_OVF_COUNT_EN
    ovf_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ov0, yr0, yi0, oop0, ovf0} !== '0 || {ov1, yr1, yi1, oop1, ovf1} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got %h / %h required 0",
               {ov0, yr0, yi0, oop0, ovf0}, {ov1, yr1, yi1, oop1, ovf1});
    end
`ifdef CALU_OVF_COUNT_EN
    n_checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_ovf_count got %0d/%0d required 0", cnt0, cnt1);
    end
`endif
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_ready got %b/%b required 1", rdy0, rdy1);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]  top[7] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2};
    logic [15:0] tar[7] = '{16'd3, 16'd3, 16'd3, 16'd30000, 16'd16384, 16'h8000, 16'd1};
    logic [15:0] tai[7] = '{16'd4, 16'd4, 16'd4, 16'h8AD0, 16'd0, 16'd0, 16'd0};
    logic [15:0] tbr[7] = '{16'd5, 16'd5, 16'd5, 16'd30000, 16'd16384, 16'h8000, 16'd16384};
    logic [15:0] tbi[7] = '{16'd6, 16'd6, 16'd6, 16'h8AD0, 16'd0, 16'd0, 16'd0};
    bit          sel[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [34:0] ex[7]  = '{{16'hFFF7, 16'd38, 2'd2, 1'b0},
                            {16'd39, 16'd2, 2'd3, 1'b0},
                            {16'hFFFE, 16'hFFFE, 2'd1, 1'b0},
                            {16'h7FFF, 16'h8000, 2'd0, 1'b1},
                            {16'd8192, 16'd0, 2'd2, 1'b0},
                            {16'h7FFF, 16'd0, 2'd2, 1'b1},
                            {16'd1, 16'd0, 2'd2, 1'b0}};
    txn_t t;
    res_t r;
    logic [34:0] got_c, got_m, exp_m;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, top[i], tar[i], tai[i], tbr[i], tbi[i]);
      cyc();
    end
    drive(1'b0, 2'd0, '0, '0, '0, '0);
    repeat (6) cyc();
    n_checks++;
    if (inq.size() != 7 || outq.size() != 7) begin
      n_errors++;
      $display("FAIL dir_count got in=%0d out=%0d required 7/7", inq.size(), outq.size());
    end
    for (int i = 0; i < 7 && inq.size() > 0 && outq.size() > 0; i++) begin
      t = inq.pop_front();
      r = outq.pop_front();
      got_c = sel[i] ? r.r1 : r.r0;
      got_m = sel[i] ? r.r0 : r.r1;
      exp_m = model(t, sel[i] ? 0 : 15);
      n_checks++;
      if (got_c !== ex[i]) begin
        n_errors++;
        $display("FAIL dir%0d_const got %h required %h", i, got_c, ex[i]);
      end
      n_checks++;
      if (got_m !== exp_m || r.v1 !== 1'b1) begin
        n_errors++;
        $display("FAIL dir%0d_model got %h v=%b required %h", i, got_m, r.v1, exp_m);
      end
      n_checks++;
      if (r.cyc - t.cyc != 3) begin
        n_errors++;
        $display("FAIL dir%0d_latency got %0d required 3", i, r.cyc - t.cyc);
      end
    end
    inq.delete(); outq.delete();
  endtask

  task automatic test_random();
    txn_t t;
    res_t r;
    logic [34:0] e0, e1;
    for (int k = 0; k < 300; k++) begin
      out_ready = ($urandom % 4) != 0;
      drive(($urandom % 4) != 0, 2'($urandom), rnd16(), rnd16(), rnd16(), rnd16());
      cyc();
    end
    out_ready = 1'b1;
    drive(1'b0, 2'd0, '0, '0, '0, '0);
    repeat (8) cyc();
    n_checks++;
    if (inq.size() != outq.size() || inq.size() < 100) begin
      n_errors++;
      $display("FAIL rand_count got out=%0d required in=%0d (>=100)", outq.size(), inq.size());
    end
    while (inq.size() > 0 && outq.size() > 0) begin
      t = inq.pop_front();
      r = outq.pop_front();
      e0 = model(t, 0);
      e1 = model(t, 15);
      n_checks++;
      if (r.r0 !== e0) begin
        n_errors++;
        $display("FAIL rand_f0 op=%0d a=%h,%h b=%h,%h got %h required %h",
                 t.op, t.ar, t.ai, t.br, t.bi, r.r0, e0);
      end
      n_checks++;
      if (r.r1 !== e1 || r.v1 !== 1'b1) begin
        n_errors++;
        $display("FAIL rand_f15 op=%0d a=%h,%h b=%h,%h got %h v=%b required %h",
                 t.op, t.ar, t.ai, t.br, t.bi, r.r1, r.v1, e1);
      end
    end
    inq.delete(); outq.delete();
  endtask

  task automatic test_backpressure();
    logic [15:0] mar[6], mai[6], mbr[6], mbi[6];
    logic [34:0] snap0, snap1, e0, e1;
    int   idx = 0;
    int   nstall = 0;
    bit   stalled;
    txn_t t;
    res_t r;
    for (int i = 0; i < 6; i++) begin
      mar[i] = rnd16(); mai[i] = rnd16(); mbr[i] = rnd16(); mbi[i] = rnd16();
    end
    for (int k = 0; k < 30; k++) begin
      out_ready = (k >= 5);
      if (idx < 6) drive(1'b1, 2'd2, mar[idx], mai[idx], mbr[idx], mbi[idx]);
      else         drive(1'b0, 2'd0, '0, '0, '0, '0);
      #1;
      stalled = ov0 && !out_ready;
      snap0 = {yr0, yi0, oop0, ovf0};
      snap1 = {yr1, yi1, oop1, ovf1};
      if (stalled) begin
        nstall++;
        n_checks++;
        if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
          n_errors++;
          $display("FAIL bp_in_ready got %b/%b required 0", rdy0, rdy1);
        end
      end
      cyc();
      if (acc) idx++;
      if (stalled) begin
        n_checks++;
        if ({yr0, yi0, oop0, ovf0} !== snap0 || {yr1, yi1, oop1, ovf1} !== snap1 || ov0 !== 1'b1) begin
          n_errors++;
          $display("FAIL bp_hold got %h/%h v=%b required %h/%h v=1",
                   {yr0, yi0, oop0, ovf0}, {yr1, yi1, oop1, ovf1}, ov0, snap0, snap1);
        end
      end
    end
    n_checks++;
    if (idx != 6 || nstall != 2 || outq.size() != 6) begin
      n_errors++;
      $display("FAIL bp_count got acc=%0d stalls=%0d out=%0d required 6/2/6", idx, nstall, outq.size());
    end
    for (int i = 0; i < 6 && inq.size() > 0 && outq.size() > 0; i++) begin
      t = inq.pop_front();
      r = outq.pop_front();
      e0 = model(t, 0);
      e1 = model(t, 15);
      n_checks++;
      if (r.r0 !== e0 || r.r1 !== e1 || t.ar !== mar[i]) begin
        n_errors++;
        $display("FAIL bp_result%0d got %h/%h required %h/%h", i, r.r0, r.r1, e0, e1);
      end
    end
    inq.delete(); outq.delete();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i + 1), rnd16(), rnd16(), 16'd7, 16'd9);
      cyc();
    end
    drive(1'b0, 2'd0, '0, '0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ov0, yr0, yi0, oop0, ovf0} !== '0 || {ov1, yr1, yi1, oop1, ovf1} !== '0) begin
      n_errors++;
      $display("FAIL async_reset got %h / %h required 0",
               {ov0, yr0, yi0, oop0, ovf0}, {ov1, yr1, yi1, oop1, ovf1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    inq.delete(); outq.delete();
    repeat (8) cyc();
    n_checks++;
    if (outq.size() != 0 || ov0 !== 1'b0 || ov1 !== 1'b0) begin
      n_errors++;
      $display("FAIL async_stale got %0d results required 0", outq.size());
    end
    outq.delete();
  endtask

`ifdef CALU_OVF_COUNT_EN
  task automatic test_ovf_count();
    out_ready = 1'b1;
    ovf_clr = 1'b1;
    drive(1'b0, 2'd0, '0, '0, '0, '0);
    cyc();
    ovf_clr = 1'b0;
    n_checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      n_errors++;
      $display("FAIL cnt_clear0 got %0d/%0d required 0", cnt0, cnt1);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd0, 16'd30000, 16'h8AD0, 16'd30000, 16'h8AD0);
      cyc();
    end
    drive(1'b1, 2'd0, 16'd1, 16'd2, 16'd3, 16'd4);
    cyc();
    drive(1'b0, 2'd0, '0, '0, '0, '0);
    repeat (6) cyc();
    n_checks++;
    if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin
      n_errors++;
      $display("FAIL cnt_two got %0d/%0d required 2", cnt0, cnt1);
    end
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    n_checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      n_errors++;
      $display("FAIL cnt_clear got %0d/%0d required 0", cnt0, cnt1);
    end
    inq.delete(); outq.delete();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_async_reset();
`ifdef CALU_OVF_COUNT_EN
    test_ovf_count();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/complex_alu_pipe.md
Name: complex_alu_pipe

Overview:
- Parametrised, pipelined complex-number ALU. Successor to the fixed 16-bit add/multiply block.
- Supports add, subtract, Gauss 3-multiplier multiply and conjugate multiply, selected per transaction.
- Uses valid/ready handshakes on input and output, with fixed-point scaling, rounding and saturation.
- Sits between the sample source and the downstream filter and accumulator stages of the complex datapath.

Parameters:
- DW, 16: signed width of each real and imaginary operand and result component.
- FRAC, 0: number of fractional bits. Multiply results are shifted right by FRAC with rounding. Legal range 0..DW-1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operand transaction present.
- in_ready, output, 1: block accepts a transaction this cycle.
- op, input, 2: operation code. 00 ADD (a+b), 01 SUB (a-b), 10 MUL (a*b), 11 CMUL (a*conj(b)).
- a_re, a_im, b_re, b_im, input, DW each: signed operands.
- out_valid, output, 1: result present.
- out_ready, input, 1: downstream accepts the result.
- y_re, y_im, output, DW each: signed result.
- out_op, output, 2: op code that travels with the result.
- ovf, output, 1: at least one result component saturated.

Behaviour:
- Reset: every pipeline valid bit clears to 0. out_valid=0. y_re, y_im, out_op and ovf are 0. Reset is asynchronous, so a reset mid-operation discards all in-flight transactions.
- First cycle after reset release: in_ready=1.
- Pipeline has 3 stages, with a fixed latency of 3 cycles from an accepted input to out_valid for every op. Results stay in order.
- S1 stage:
  - Register operands and op.
  - Form pre-sums at DW+1 bits.
  - MUL: p = a_re+a_im, q = b_re+b_im.
  - CMUL: b_im is negated at DW+1 bits before the pre-sum, so -(-2^(DW-1)) is exact.
  - ADD/SUB: form the component sum or difference at DW+1 bits.
- S2 stage:
  - MUL/CMUL: three signed products k1 = a_re*b_re', k2 = a_im*b_im', k3 = p*q, each 2*DW+2 bits. b' is b for MUL and conj(b) for CMUL.
  - ADD/SUB: the sum passes through unchanged.
- S3 stage:
  - MUL/CMUL: re = k1-k2, im = k3-k1-k2, computed at 2*DW+3 bits.
  - If FRAC>0, add 2^(FRAC-1), then shift right arithmetically by FRAC (round half up).
  - Saturate each component to [-2^(DW-1), 2^(DW-1)-1].
  - ADD/SUB: no shift is applied, but the same saturation is.
  - ovf = saturation on re OR on im.
- Stall rule:
  - en = !out_valid || out_ready. When en=1, all stages advance together; when en=0, all stages hold.
  - in_ready = en. A transfer occurs when in_valid && in_ready.
  - A bubble, meaning in_valid=0 while en=1, enters S1 with valid=0.
- Output hold: while out_valid && !out_ready, y_re, y_im, out_op and ovf are stable.
- Simultaneous events: on a cycle with out_valid && out_ready && in_valid, the block accepts the new input and retires the old result in the same cycle. This gives full throughput of one transaction per clock.
- Data outputs hold their last value when out_valid=0.

Optional Feature:
- Macro CALU_OVF_COUNT_EN.
- When defined, adds output ovf_count [15:0], a saturating count of retired results with ovf=1. A result retires when out_valid && out_ready && ovf.
  - Stops counting at 16'hFFFF.
  - Reset value is 0.
  - Adds input ovf_clr, 1 bit, which clears the count synchronously. If a clear and an increment occur in the same cycle, the clear wins.
- When undefined, these ports and the counter do not exist, and the remaining behaviour is identical.

Test Plan:
- DW=16, FRAC=0: MUL (3+4j)*(5+6j) -> y=-9+38j, ovf=0, out_valid exactly 3 cycles after acceptance.
- CMUL (3+4j)*(5+6j) -> 39+2j. SUB (3+4j)-(5+6j) -> -2-2j. Issue all back-to-back with out_ready=1: three consecutive out_valid cycles, in order.
- ADD (30000-30000j)+(30000-30000j) -> 32767-32768j, ovf=1.
- DW=16, FRAC=15: MUL 16384*16384 (real only) -> y_re=8192. MUL (-32768)*(-32768) -> y_re=32767, ovf=1. MUL 1*16384 -> 1 (rounded from 0.5).
- Back-pressure: stream 6 MULs with out_ready=0 for 5 cycles -> in_ready drops once out_valid=1, outputs stay stable, all 6 results arrive in order after out_ready=1, none lost or duplicated.
- Assert rst_n low while 3 ops are in flight -> out_valid=0 and outputs 0 immediately (asynchronous), with no stale result after release. With CALU_OVF_COUNT_EN: 2 saturating ADDs -> ovf_count=2; ovf_clr -> 0.
